// File: rtl/timer_status_irq.sv
// ============================================================================
//  Module      : timer_status_irq
//  Description : OPL3 timer control register 0x04, FT1/FT2 status flags,
//                host status byte and interrupt line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_status_irq #(
    parameter bit CLR_ON_READ    = 1'b0,
    parameter bit IRQ_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_status,
    input  logic       timer1_overflow,
    input  logic       timer2_overflow,
    output logic       start_timer1,
    output logic       start_timer2,
    output logic [7:0] status,
    output logic       irq
);

    logic mt1_q, mt1_d;
    logic mt2_q, mt2_d;
    logic st1_q, st1_d;
    logic st2_q, st2_d;
    logic ft1_q, ft1_d;
    logic ft2_q, ft2_d;
    logic prev1_q, prev2_q;

    logic w_rise1, w_rise2;
    logic w_set1, w_set2;
    logic w_clear;
    logic w_load;
    logic w_irq_flag;

    assign w_rise1 = timer1_overflow & ~prev1_q;
    assign w_rise2 = timer2_overflow & ~prev2_q;

    // Qualifiers use the current (pre-write) ST/MT values.
    assign w_set1  = w_rise1 & st1_q & ~mt1_q;
    assign w_set2  = w_rise2 & st2_q & ~mt2_q;

    assign w_clear = (wr_en & wr_data[7]) | (CLR_ON_READ & rd_status);
    assign w_load  = wr_en & ~wr_data[7];

    always_comb begin
        mt1_d = mt1_q;
        mt2_d = mt2_q;
        st1_d = st1_q;
        st2_d = st2_q;
        if (w_load) begin
            mt1_d = wr_data[6];
            mt2_d = wr_data[5];
            st2_d = wr_data[1];
            st1_d = wr_data[0];
        end
    end

    // A set in the same cycle as a clear wins.
    always_comb begin
        ft1_d = ft1_q;
        ft2_d = ft2_q;
        if (w_clear) begin
            ft1_d = 1'b0;
            ft2_d = 1'b0;
        end
        if (w_set1) ft1_d = 1'b1;
        if (w_set2) ft2_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mt1_q   <= 1'b0;
            mt2_q   <= 1'b0;
            st1_q   <= 1'b0;
            st2_q   <= 1'b0;
            ft1_q   <= 1'b0;
            ft2_q   <= 1'b0;
            prev1_q <= 1'b0;
            prev2_q <= 1'b0;
        end else begin
            mt1_q   <= mt1_d;
            mt2_q   <= mt2_d;
            st1_q   <= st1_d;
            st2_q   <= st2_d;
            ft1_q   <= ft1_d;
            ft2_q   <= ft2_d;
            prev1_q <= timer1_overflow;
            prev2_q <= timer2_overflow;
        end
    end

    assign w_irq_flag   = ft1_q | ft2_q;
    assign status       = {w_irq_flag, ft1_q, ft2_q, 5'b0_0000};
    assign irq          = IRQ_ACTIVE_LOW ? ~w_irq_flag : w_irq_flag;
    assign start_timer1 = st1_q;
    assign start_timer2 = st2_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_status_irq.sv
// ============================================================================
//  Module      : tb_timer_status_irq
//  Description : Self-checking bench; instance A uses default parameters,
//                instance B clears on read with an active-high irq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_status_irq;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_status;
    logic       t1_ov;
    logic       t2_ov;

    logic       st1_a, st2_a, irq_a, st1_b, st2_b, irq_b;
    logic [7:0] status_a, status_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    timer_status_irq #(.CLR_ON_READ(1'b0), .IRQ_ACTIVE_LOW(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .rd_status(rd_status), .timer1_overflow(t1_ov), .timer2_overflow(t2_ov),
        .start_timer1(st1_a), .start_timer2(st2_a), .status(status_a), .irq(irq_a)
    );

    timer_status_irq #(.CLR_ON_READ(1'b1), .IRQ_ACTIVE_LOW(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .rd_status(rd_status), .timer1_overflow(t1_ov), .timer2_overflow(t2_ov),
        .start_timer1(st1_b), .start_timer2(st2_b), .status(status_b), .irq(irq_b)
    );

    // Reference model: index 0 = timer 1, index 1 = timer 2.
    bit m_mt   [2];
    bit m_st   [2];
    bit m_prev [2];
    bit m_ft_a [2];
    bit m_ft_b [2];

    always @(posedge clk) begin
        bit ov [2];
        bit hit;
        bit wclr;
        ov[0] = t1_ov;
        ov[1] = t2_ov;
        wclr  = wr_en && wr_data[7];
        for (int n = 0; n < 2; n++) begin
            if (reset) begin
                m_mt[n]   <= 1'b0;
                m_st[n]   <= 1'b0;
                m_prev[n] <= 1'b0;
                m_ft_a[n] <= 1'b0;
                m_ft_b[n] <= 1'b0;
            end else begin
                hit = ov[n] && !m_prev[n] && m_st[n] && !m_mt[n];
                m_ft_a[n] <= hit || (m_ft_a[n] && !wclr);
                m_ft_b[n] <= hit || (m_ft_b[n] && !wclr && !rd_status);
                m_prev[n] <= ov[n];
            end
        end
        if (!reset && wr_en && !wr_data[7]) begin
            m_mt[0] <= wr_data[6];
            m_mt[1] <= wr_data[5];
            m_st[0] <= wr_data[0];
            m_st[1] <= wr_data[1];
        end
    end

    function automatic logic [7:0] exp_status(bit f1, bit f2);
        return {f1 | f2, f1, f2, 5'b0_0000};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model status_a", status_a, exp_status(m_ft_a[0], m_ft_a[1]));
            chk("model status_b", status_b, exp_status(m_ft_b[0], m_ft_b[1]));
            chk("model irq_a", {7'd0, irq_a}, {7'd0, !(m_ft_a[0] || m_ft_a[1])});
            chk("model irq_b", {7'd0, irq_b}, {7'd0, m_ft_b[0] || m_ft_b[1]});
            chk("model start_a", {6'd0, st2_a, st1_a}, {6'd0, m_st[1], m_st[0]});
            chk("model start_b", {6'd0, st2_b, st1_b}, {6'd0, m_st[1], m_st[0]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_status = 1'b0;
        t1_ov = 1'b0; t2_ov = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        reset  = 1'b0;
        chk("reset status", status_a, 8'h00);
        chk("reset irq_a", {7'd0, irq_a}, 8'h01);
        chk("reset irq_b", {7'd0, irq_b}, 8'h00);
        chk("reset start1", {7'd0, st1_a}, 8'h00);

        // Basic start and flag set
        wr(8'h01);
        chk("start1 after write", {7'd0, st1_a}, 8'h01);
        t1_ov = 1'b1; cyc(); t1_ov = 1'b0;
        chk("ft1 set status", status_a, 8'hC0);
        chk("ft1 set irq_a", {7'd0, irq_a}, 8'h00);
        chk("ft1 set irq_b", {7'd0, irq_b}, 8'h01);
        cyc();

        // Both flags then RST write
        wr(8'h03);
        t2_ov = 1'b1; cyc(); t2_ov = 1'b0;
        chk("both flags", status_a, 8'hE0);
        wr(8'h80);
        chk("rst clears", status_a, 8'h00);
        chk("rst keeps start", {6'd0, st2_a, st1_a}, 8'h03);

        // Mask blocks new sets but keeps existing flag
        wr(8'h43);
        t1_ov = 1'b1; cyc(); t1_ov = 1'b0;
        chk("masked no set", status_a, 8'h00);
        chk("masked irq idle", {7'd0, irq_a}, 8'h01);
        cyc();
        wr(8'h03);
        t1_ov = 1'b1; cyc(); t1_ov = 1'b0;
        chk("unmasked set", status_a, 8'hC0);
        wr(8'h43);
        chk("mask keeps flag", status_a, 8'hC0);
        wr(8'h80);
        chk("clear masked flag", status_a, 8'h00);
        wr(8'h03);

        // RST write together with a T2 rise
        t1_ov = 1'b1; cyc(); t1_ov = 1'b0;
        wr_en = 1'b1; wr_data = 8'h80; t2_ov = 1'b1;
        cyc();
        wr_en = 1'b0; t2_ov = 1'b0;
        chk("set beats rst", status_a, 8'hA0);
        wr(8'h80);
        chk("clear ft2", status_a, 8'h00);

        // Level-held overflow: one set per rising edge
        t1_ov = 1'b1; cyc();
        chk("level first set", status_a, 8'hC0);
        repeat (300) cyc();
        wr(8'h80);
        chk("level cleared", status_a, 8'h00);
        repeat (600) cyc();
        chk("level no reset", status_a, 8'h00);
        t1_ov = 1'b0; cyc();
        t1_ov = 1'b1; cyc();
        chk("fresh rise sets", status_a, 8'hC0);
        t1_ov = 1'b0;
        wr(8'h80);

        // Stopped timers never set
        wr(8'h00);
        t1_ov = 1'b1; t2_ov = 1'b1; cyc(); t1_ov = 1'b0; t2_ov = 1'b0;
        chk("stopped no set", status_a, 8'h00);
        chk("stopped start1", {7'd0, st1_a}, 8'h00);

        // ST write with simultaneous rise uses old ST
        wr_en = 1'b1; wr_data = 8'h01; t1_ov = 1'b1;
        cyc();
        wr_en = 1'b0; t1_ov = 1'b0;
        chk("old st=0 blocks", status_a, 8'h00);
        chk("new st1 on", {7'd0, st1_a}, 8'h01);
        cyc();
        wr_en = 1'b1; wr_data = 8'h00; t1_ov = 1'b1;
        cyc();
        wr_en = 1'b0; t1_ov = 1'b0;
        chk("old st=1 sets", status_a, 8'hC0);
        chk("new st1 off", {7'd0, st1_a}, 8'h00);
        wr(8'h80);
        wr(8'h03);

        // Clear-on-read behaviour (instance B)
        t2_ov = 1'b1; cyc(); t2_ov = 1'b0;
        rd_status = 1'b1; #1;
        chk("read pre-clear b", status_b, 8'hA0);
        cyc();
        rd_status = 1'b0;
        chk("read cleared b", status_b, 8'h00);
        chk("read no clear a", status_a, 8'hA0);
        chk("read irq_b idle", {7'd0, irq_b}, 8'h00);
        rd_status = 1'b1; t2_ov = 1'b1;
        cyc();
        rd_status = 1'b0; t2_ov = 1'b0;
        chk("set beats read b", status_b, 8'hA0);
        wr_en = 1'b1; wr_data = 8'h80; rd_status = 1'b1; t1_ov = 1'b1;
        cyc();
        wr_en = 1'b0; rd_status = 1'b0; t1_ov = 1'b0;
        chk("wr+rd+rise a", status_a, 8'hC0);
        chk("wr+rd+rise b", status_b, 8'hC0);

        // Reset with a flag set
        reset = 1'b1; cyc();
        chk("reset mid status", status_a, 8'h00);
        chk("reset mid start", {6'd0, st2_a, st1_a}, 8'h00);
        reset = 1'b0;
        cyc(); cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
